// File: rtl/collatz_bus_master.sv
// Bus master that walks one Collatz trajectory down to 1 through the
// mode-switching peripheral, with step limit, overflow guard and bus timeout.
module collatz_bus_master #(
    parameter int MAX_STEPS = 255,
    parameter int TIMEOUT   = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] start_value,
    input  logic       readyout,
    input  logic [7:0] rdata,
    output logic       write,
    output logic       trans,
    output logic [7:0] waddr,
    output logic [7:0] wdata,
    output logic [7:0] value,
    output logic [7:0] steps,
    output logic       busy,
    output logic       done,
    output logic [2:0] err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    MAX_STEPS_L = 8'(MAX_STEPS);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WR, S_GAP, S_RD, S_DONE, S_ERR
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    value_reg, value_next;
    logic [7:0]    steps_reg, steps_next;
    logic [2:0]    err_reg, err_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_IDLE;
            value_reg <= 8'd0;
            steps_reg <= 8'd0;
            err_reg   <= 3'd0;
            tcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            value_reg <= value_next;
            steps_reg <= steps_next;
            err_reg   <= err_next;
            tcnt_reg  <= tcnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        value_next = value_reg;
        steps_next = steps_reg;
        err_next   = err_reg;
        tcnt_next  = tcnt_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    value_next = start_value;
                    steps_next = 8'd0;
                    err_next   = 3'd0;
                    if (start_value == 8'd0) begin
                        state_next = S_ERR;
                        err_next   = 3'd1;
                    end else begin
                        state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (value_reg == 8'd1) begin
                    state_next = S_DONE;
                end else if (steps_reg == MAX_STEPS_L) begin
                    state_next = S_ERR;
                    err_next   = 3'd3;
                end else if (value_reg[0] && value_reg >= 8'd85) begin
                    // 3n+1 would no longer fit in 8 bits
                    state_next = S_ERR;
                    err_next   = 3'd2;
                end else begin
                    state_next = S_WR;
                    tcnt_next  = '0;
                end
            end
            S_WR: begin
                if (readyout) begin
                    state_next = S_GAP;
                end else if (tcnt_reg == TO_LAST) begin
                    state_next = S_ERR;
                    err_next   = 3'd4;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            S_GAP: begin
                state_next = S_RD;
                tcnt_next  = '0;
            end
            S_RD: begin
                if (readyout) begin
                    value_next = rdata;
                    steps_next = steps_reg + 8'd1;
                    state_next = (rdata == 8'd1) ? S_DONE : S_CHECK;
                end else if (tcnt_reg == TO_LAST) begin
                    state_next = S_ERR;
                    err_next   = 3'd4;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Bus outputs decode straight from the state register, so they cannot
    // move while a transfer is held waiting for readyout.
    assign trans = (state_reg == S_WR) || (state_reg == S_RD);
    assign write = (state_reg == S_WR);
    assign waddr = (state_reg == S_RD) ? value_reg : 8'd0;
    assign wdata = (state_reg == S_WR) ? {7'b0, value_reg[0]} : 8'd0;
    assign value = value_reg;
    assign steps = steps_reg;
    assign busy  = (state_reg == S_CHECK) || (state_reg == S_WR) ||
                   (state_reg == S_GAP)   || (state_reg == S_RD);
    assign done  = (state_reg == S_DONE);
    assign err   = err_reg;

endmodule

// File: tb/tb_collatz_bus_master.sv
// Directed bench: default instance against a peripheral model, plus
// instances with a short step limit and with readyout tied low.
module tb_collatz_bus_master;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // main instance
    logic       start = 1'b0;
    logic [7:0] start_value = 8'd0;
    logic       readyout = 1'b0;
    logic [7:0] rdata = 8'd0;
    logic       write, trans, busy, done;
    logic [7:0] waddr, wdata, value, steps;
    logic [2:0] err;

    collatz_bus_master dut (
        .clock(clock), .reset(reset), .start(start), .start_value(start_value),
        .readyout(readyout), .rdata(rdata), .write(write), .trans(trans),
        .waddr(waddr), .wdata(wdata), .value(value), .steps(steps),
        .busy(busy), .done(done), .err(err)
    );

    // step-limit instance
    logic       ms_start = 1'b0;
    logic [7:0] ms_sv = 8'd0;
    logic       ms_ready = 1'b0;
    logic [7:0] ms_rdata = 8'd0;
    logic       ms_write, ms_trans, ms_busy, ms_done;
    logic [7:0] ms_waddr, ms_wdata, ms_value, ms_steps;
    logic [2:0] ms_err;

    collatz_bus_master #(.MAX_STEPS(3)) dut_ms (
        .clock(clock), .reset(reset), .start(ms_start), .start_value(ms_sv),
        .readyout(ms_ready), .rdata(ms_rdata), .write(ms_write), .trans(ms_trans),
        .waddr(ms_waddr), .wdata(ms_wdata), .value(ms_value), .steps(ms_steps),
        .busy(ms_busy), .done(ms_done), .err(ms_err)
    );

    // timeout instance, peripheral never answers
    logic       to_start = 1'b0;
    logic [7:0] to_sv = 8'd0;
    logic       to_write, to_trans, to_busy, to_done;
    logic [7:0] to_waddr, to_wdata, to_value, to_steps;
    logic [2:0] to_err;

    collatz_bus_master #(.TIMEOUT(16)) dut_to (
        .clock(clock), .reset(reset), .start(to_start), .start_value(to_sv),
        .readyout(1'b0), .rdata(8'h00), .write(to_write), .trans(to_trans),
        .waddr(to_waddr), .wdata(to_wdata), .value(to_value), .steps(to_steps),
        .busy(to_busy), .done(to_done), .err(to_err)
    );

    // Peripheral models: one-cycle latency, readyout pulses once per transfer.
    logic m_mode = 1'b0;
    logic ms_mode = 1'b0;
    always @(posedge clock) begin
        readyout <= trans & ~readyout;
        if (trans && !readyout) begin
            if (write) m_mode <= wdata[0];
            else rdata <= m_mode ? (waddr * 8'd3 + 8'd1) : (waddr >> 1);
        end
        ms_ready <= ms_trans & ~ms_ready;
        if (ms_trans && !ms_ready) begin
            if (ms_write) ms_mode <= ms_wdata[0];
            else ms_rdata <= ms_mode ? (ms_waddr * 8'd3 + 8'd1) : (ms_waddr >> 1);
        end
    end

    // Completed transfers, and protocol violations on the main bus.
    int xfers = 0;
    int viol = 0;
    logic       prev_trans = 1'b0;
    logic       prev_write = 1'b0;
    logic [15:0] prev_bus = 16'd0;
    always @(negedge clock) begin
        if (trans && readyout) xfers = xfers + 1;
        if (prev_trans && trans && (write != prev_write || {waddr, wdata} != prev_bus))
            viol = viol + 1;
        prev_trans = trans;
        prev_write = write;
        prev_bus   = {waddr, wdata};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run(input logic [7:0] sv, input int poke, output int cyc);
        @(negedge clock);
        start = 1'b1;
        start_value = sv;
        @(negedge clock);
        start = 1'b0;
        cyc = 0;
        while (!(done || err != 3'd0) && cyc < 400) begin
            if (poke != 0 && cyc == poke) begin
                start = 1'b1;
                start_value = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 400) check("run_timeout", 64'(cyc), 64'd0);
    endtask

    typedef struct {
        logic [7:0] sv;
        int         poke;
        logic       done;
        logic [2:0] err;
        logic [7:0] steps;
        logic [7:0] value;
        int         cycles;
        int         xfers;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int cyc;
        int x0;
        int n;

        vecs[0] = '{8'd6,  0,  1'b1, 3'd0, 8'd8,  8'd1,   48, 16};
        vecs[1] = '{8'd1,  0,  1'b1, 3'd0, 8'd0,  8'd1,   1,  0};
        vecs[2] = '{8'd0,  0,  1'b0, 3'd1, 8'd0,  8'd0,   0,  0};
        vecs[3] = '{8'd85, 0,  1'b0, 3'd2, 8'd0,  8'd85,  1,  0};
        vecs[4] = '{8'd27, 0,  1'b0, 3'd2, 8'd11, 8'd107, 67, 22};
        vecs[5] = '{8'd2,  0,  1'b1, 3'd0, 8'd1,  8'd1,   6,  2};
        vecs[6] = '{8'd7,  0,  1'b1, 3'd0, 8'd16, 8'd1,   96, 32};
        vecs[7] = '{8'd6,  10, 1'b1, 3'd0, 8'd8,  8'd1,   48, 16};

        repeat (3) @(negedge clock);
        check("reset_outputs",
              64'({trans, write, waddr, wdata, value, steps, busy, done, err}), 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            x0 = xfers;
            run(vecs[i].sv, vecs[i].poke, cyc);
            $display("run sv=%0d poke=%0d cycles=%0d done=%0d err=%0d steps=%0d value=%0d xfers=%0d",
                     vecs[i].sv, vecs[i].poke, cyc, done, err, steps, value, xfers - x0);
            check("done",   64'(done),        64'(vecs[i].done));
            check("err",    64'(err),         64'(vecs[i].err));
            check("steps",  64'(steps),       64'(vecs[i].steps));
            check("value",  64'(value),       64'(vecs[i].value));
            check("cycles", 64'(cyc),         64'(vecs[i].cycles));
            check("xfers",  64'(xfers - x0),  64'(vecs[i].xfers));
            check("busy",   64'(busy),        64'd0);
        end

        // step limit of 3 from 6: 3, 10, 5 then stop
        @(negedge clock);
        ms_start = 1'b1;
        ms_sv = 8'd6;
        @(negedge clock);
        ms_start = 1'b0;
        n = 0;
        while (ms_err == 3'd0 && !ms_done && n < 200) begin
            @(negedge clock);
            n++;
        end
        $display("maxsteps cycles=%0d err=%0d steps=%0d value=%0d", n, ms_err, ms_steps, ms_value);
        check("ms_err",    64'(ms_err),   64'd3);
        check("ms_steps",  64'(ms_steps), 64'd3);
        check("ms_value",  64'(ms_value), 64'd5);
        check("ms_cycles", 64'(n),        64'd19);

        // readyout never arrives: first write held 16 cycles then abort
        @(negedge clock);
        to_start = 1'b1;
        to_sv = 8'd6;
        @(negedge clock);
        to_start = 1'b0;
        n = 0;
        while (!to_trans && n < 5) begin
            @(negedge clock);
            n++;
        end
        n = 0;
        while (to_trans && n < 100) begin
            @(negedge clock);
            n++;
        end
        $display("timeout trans_cycles=%0d err=%0d", n, to_err);
        check("to_trans_cycles", 64'(n),        64'd16);
        check("to_err",          64'(to_err),   64'd4);
        check("to_value",        64'(to_value), 64'd6);
        check("to_steps",        64'(to_steps), 64'd0);
        check("to_busy",         64'(to_busy),  64'd0);

        // reset in the middle of a read transfer
        @(negedge clock);
        start = 1'b1;
        start_value = 8'd6;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!(trans && !write) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("reached_rd", 64'(trans && !write), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        $display("reset mid-RD trans=%0d value=%0d steps=%0d", trans, value, steps);
        check("reset_mid_rd",
              64'({trans, write, waddr, wdata, value, steps, busy, done, err}), 64'd0);
        reset = 1'b0;
        x0 = xfers;
        run(8'd6, 0, cyc);
        $display("restart sv=6 cycles=%0d done=%0d steps=%0d", cyc, done, steps);
        check("restart_done",   64'(done),       64'd1);
        check("restart_steps",  64'(steps),      64'd8);
        check("restart_cycles", 64'(cyc),        64'd48);
        check("restart_xfers",  64'(xfers - x0), 64'd16);

        check("bus_protocol", 64'(viol), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/collatz_bus_master.md
Name: collatz_bus_master

Overview:
- Bus-master stage directly upstream of the mode-switching peripheral (even mode: rdata = waddr>>1; odd mode: rdata = 3*waddr+1).
- Drives one Collatz trajectory from a start value down to 1 over the write/trans/waddr/wdata bus.
- Every transfer is handshaked on readyout.
- Replaces free-running sequencing with a start/done interface, a step counter, an overflow guard and a bus timeout.

Parameters:
- MAX_STEPS, 255: step limit; reaching it without hitting 1 is an error.
- TIMEOUT, 64: max cycles a transfer may wait for readyout before abort.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  begin run; sampled only in IDLE/DONE/ERR
- start_value  input  8  initial Collatz value, captured with start
- readyout  input  1  peripheral transfer-complete
- rdata  input  8  peripheral read data
- write  output  1  1 = write transfer, 0 = read
- trans  output  1  transfer active
- waddr  output  8  transfer address
- wdata  output  8  write data
- value  output  8  current Collatz value
- steps  output  8  completed steps
- busy  output  1  run in progress
- done  output  1  level; trajectory reached 1
- err  output  3  0 none, 1 zero start, 2 overflow, 3 step limit, 4 timeout

Behaviour:
- Reset (synchronous, active-high, wins over everything): state IDLE.
  - trans=0, write=0, waddr=0, wdata=0, value=0, steps=0.
  - busy=0, done=0, err=0; timeout counter cleared.
  - Reset mid-transfer drops trans on the next edge; no further bus activity until a new start.
- States: IDLE, CHECK, WR, GAP, RD, DONE, ERR.
- IDLE/DONE/ERR with start=1:
  - value<=start_value, steps<=0, done<=0, err<=0, busy<=1.
  - start_value==0 goes straight to ERR with err=1; otherwise go to CHECK.
- CHECK (trans=0, one cycle). Priority order:
  - value==1: DONE.
  - steps==MAX_STEPS: ERR, err=3.
  - value odd and value>=85 (3n+1 would exceed 255): ERR, err=2.
  - Otherwise WR.
- WR: write=1, trans=1, waddr=0, wdata={7'b0,value[0]}.
  - Hold all bus outputs until readyout sampled 1, then go to GAP.
- GAP: trans=0 for exactly one cycle, so the peripheral clears readyout; then RD.
- RD: write=0, trans=1, waddr=value.
  - On readyout=1: value<=rdata, steps<=steps+1, trans<=0.
  - rdata==1: DONE; otherwise CHECK.
- Handshake:
  - readyout is sampled only in WR/RD and ignored elsewhere.
  - Bus outputs are stable while trans=1.
  - With a 1-cycle-latency peripheral, each transfer occupies 2 cycles and each step exactly 6 cycles (CHECK+WR2+GAP+RD2).
- Timeout: counter clears on entry to WR/RD and increments each cycle readyout=0.
  - Reaching TIMEOUT: trans<=0, go to ERR, err=4.
  - value and steps hold their last values.
- DONE: done=1, busy=0, trans=0; outputs hold until start or reset.
- ERR: err holds, busy=0, done=0, trans=0; exits only via start or reset.
- start while busy is ignored.
- steps never wraps: the MAX_STEPS check happens before any increment beyond it.

Test Plan:
- start_value=6, real peripheral:
  - Trajectory 3,10,5,16,8,4,2,1.
  - done rises 48 cycles after the start edge; steps=8, value=1, err=0.
  - Exactly 16 transfers, each write followed by a one-cycle trans=0 gap.
- start_value=1 -> DONE after one CHECK cycle; steps=0, no trans pulse.
- start_value=0 -> err=1 next cycle, no bus activity.
- start_value=85 -> err=2 after CHECK, steps=0.
- start_value=27 -> err=2 with value=107, steps=11.
- MAX_STEPS=3, start_value=6 -> err=3, steps=3, value=5.
- readyout tied 0, TIMEOUT=16 -> trans high 16 cycles in the first WR, then trans=0 and err=4.
- reset asserted mid-RD -> all outputs at reset values next cycle.
- New start issued 1 cycle after reset released -> completes normally (stale readyout ignored).
